btn_event_filter: RTL and testbench
===================================

# btn_event_filter

- Input-conditioning stage between the raw board buttons and the button-driven memory access logic in the top level.
- Synchronises each asynchronous button and debounces it with a per-button stable-time counter.
- Emits single-cycle press/release event pulses, with optional auto-repeat on selected buttons, so downstream logic consumes clean events instead of tracking a released flag.

## Interface

Parameters:
- N_BTN, 4, number of buttons.
- DEBOUNCE_CYCLES, 1_000_000, consecutive cycles a changed level must persist to be accepted; must be >= 1.
- REPEAT_DELAY, 50_000_000, cycles from initial press pulse to first repeat pulse; 0 disables auto-repeat for all buttons.
- REPEAT_PERIOD, 10_000_000, cycles between subsequent repeat pulses; must be >= 1.
- REPEAT_MASK, 4'b0001, N_BTN bits; bit i set enables auto-repeat on button i.

Ports:
- clk_i, input, 1, single clock domain.
- rst_i, input, 1, reset; asynchronous, active-high.
- btn_i, input, N_BTN, raw asynchronous button levels, 1 = pressed.
- level_o, output, N_BTN, debounced registered level.
- press_o, output, N_BTN, one-cycle pulse per accepted press or repeat.
- release_o, output, N_BTN, one-cycle pulse per accepted release.
- any_level_o, output, 1, OR of level_o (combinational from level_o).

## Operation

- **Reset:** all synchroniser flops, stable levels, counters, level_o, press_o and release_o are 0 while rst_i is high. Takes effect immediately, independent of clk_i.
- **Synchroniser:** two-flop chain per bit; s[i] is the second flop output.
- **Debounce, per button, every edge:**
  - If s[i] == level_o[i]: debounce counter set to 0.
  - Else, if counter == DEBOUNCE_CYCLES-1: level_o[i] <= s[i] and counter <= 0.
  - Otherwise: counter increments.
  - Any return of s[i] to the stable value before acceptance discards the partial count (glitch rejection).
- **Events:**
  - press_o[i] is 1 for exactly the cycle in which level_o[i] first reads 1.
  - release_o[i] is 1 for exactly the cycle in which level_o[i] first reads 0.
  - Both are registered, aligned with the level_o change.
- **Auto-repeat** (REPEAT_MASK[i]=1 and REPEAT_DELAY>0):
  - Hold counter is cleared on the initial press and increments each cycle level_o[i] is 1.
  - Extra press_o[i] pulses occur REPEAT_DELAY cycles after the initial pulse, then every REPEAT_PERIOD cycles while level_o[i] stays 1.
  - Release clears the hold counter; no repeat pulse coincides with release_o[i].
  - Hold counter saturates-free: it wraps back into the period phase and never overflows its width.
- **Counter widths:** $clog2 of the largest count + 1; no truncation for any legal parameter value.
- **Independence:**
  - Buttons are fully independent; several press_o bits may assert in the same cycle.
  - Prioritisation is the consumer's responsibility.
- **Held through reset:** a button held across rst_i deassertion is seen as a new press once the full latency has elapsed.

## Timing

- Raw level first sampled at edge 0 and held: level_o/press_o update at edge DEBOUNCE_CYCLES+1 (2 sync edges + DEBOUNCE_CYCLES count edges, minus overlap).
- Release latency is identical to press latency.
- Repeat pulse n (n >= 1) lands REPEAT_DELAY + (n-1)*REPEAT_PERIOD cycles after the initial press pulse.
- Minimum spacing between press and the following release pulse is DEBOUNCE_CYCLES cycles.
- any_level_o has zero cycles of latency relative to level_o.

## Test plan

All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, REPEAT_MASK=4'b0001.

- **Glitch rejection:** btn_i[0]=1 for 3 cycles, then 0 -> level_o, press_o and release_o remain 0 throughout.
- **Clean press/release:** btn_i[2] rises before edge 0 and holds 20 cycles -> level_o[2] and press_o[2] rise after edge 5; press_o[2] is 1 for one cycle; no repeat pulses (mask bit 0). After the fall, release_o[2] pulses once, 6 edges later.
- **Auto-repeat:** btn_i[0] held 40 cycles -> press_o[0] at cycle t, t+10, t+13, t+16, …; exactly one release_o[0] after the fall; no press_o[0] in the release cycle.
- **Simultaneous:** btn_i = 4'b1010 applied in one cycle -> press_o = 4'b1010 in a single cycle; any_level_o = 1 in that same cycle.
- **Reset mid-count:** btn_i[1] high; rst_i pulsed when the counter is at 3 -> all outputs 0 immediately. After deassert with btn_i[1] still high, press_o[1] occurs after the full DEBOUNCE_CYCLES+2 edges.
- **Reset while pressed:** level_o = 4'b0001 and repeating; rst_i asserted -> level_o = 0 with no release_o pulse; after deassert with btn_i released, no events.

Source files
------------

// File: rtl/btn_event_filter.sv
// btn_event_filter: synchronise, debounce and turn raw buttons into press/release/repeat pulses
module btn_event_filter #(
  parameter int N_BTN = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000,
  parameter logic [N_BTN-1:0] REPEAT_MASK = 4'b0001
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_BTN-1:0] btn_i,
  output logic [N_BTN-1:0] level_o,
  output logic [N_BTN-1:0] press_o,
  output logic [N_BTN-1:0] release_o,
  output logic             any_level_o
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RM = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW = $clog2(RM + 1);
  logic [N_BTN-1:0] s1, s;
  // two-flop synchroniser per button
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1 <= '0;
      s  <= '0;
    end else begin
      s1 <= btn_i;
      s  <= s1;
    end
  end
  assign any_level_o = |level_o;
  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    logic [DW-1:0] cnt;
    logic [HW-1:0] hold;
    logic rep, lvl, prs, rel, acc, rpt;
    // acc: changed level has persisted long enough; rpt: hold counter reached the current repeat target
    always_comb begin
      acc = s[i] != lvl && cnt == DW'(DEBOUNCE_CYCLES - 1);
      rpt = REPEAT_MASK[i] && REPEAT_DELAY > 0 && lvl && !acc &&
            hold == (rep ? HW'(REPEAT_PERIOD - 1) : HW'(REPEAT_DELAY - 1));
    end
    // debounce counter, accepted level, event pulses and repeat phase; release beats any due repeat
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        cnt  <= '0;
        hold <= '0;
        rep  <= 1'b0;
        lvl  <= 1'b0;
        prs  <= 1'b0;
        rel  <= 1'b0;
      end else begin
        cnt  <= (s[i] == lvl || acc) ? '0 : cnt + 1'b1;
        lvl  <= acc ? s[i] : lvl;
        prs  <= (acc && s[i]) || rpt;
        rel  <= acc && !s[i];
        hold <= (!lvl || acc || rpt) ? '0 : hold + 1'b1;
        rep  <= lvl && !acc && (rep || rpt);
      end
    end
    assign level_o[i]   = lvl;
    assign press_o[i]   = prs;
    assign release_o[i] = rel;
  end
endmodule

// File: tb/tb_btn_event_filter.sv
// tb_btn_event_filter: directed checks of debounce, events, auto-repeat and reset behaviour
module tb_btn_event_filter;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic [3:0] btn_i = '0;
  logic [3:0] level_o, press_o, release_o;
  logic any_level_o;
  logic [3:0] seen;
  int total = 0;
  int bad = 0;

  btn_event_filter #(
    .N_BTN(4), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3), .REPEAT_MASK(4'b0001)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .btn_i(btn_i), .level_o(level_o),
    .press_o(press_o), .release_o(release_o), .any_level_o(any_level_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    repeat (3) step();
    #1;
    chk("rst_level", level_o, 4'b0000);
    chk("rst_press", press_o, 4'b0000);
    chk("rst_release", release_o, 4'b0000);
    chk("rst_any", {3'b000, any_level_o}, 4'b0000);
    rst_i = 1'b0;
    step();

    seen = '0;
    btn_i = 4'b0001;
    repeat (3) step();
    btn_i = 4'b0000;
    repeat (10) begin
      step();
      seen |= level_o | press_o | release_o;
    end
    chk("glitch_events", seen, 4'b0000);

    btn_i = 4'b0100;
    for (int e = 0; e < 32; e++) begin
      if (e == 20) btn_i = 4'b0000;
      step();
      chk($sformatf("clean_press_e%0d", e), press_o, e == 5 ? 4'b0100 : 4'b0000);
      chk($sformatf("clean_level_e%0d", e), level_o, (e >= 5 && e < 25) ? 4'b0100 : 4'b0000);
      chk($sformatf("clean_release_e%0d", e), release_o, e == 25 ? 4'b0100 : 4'b0000);
    end

    btn_i = 4'b0001;
    for (int e = 0; e < 52; e++) begin
      if (e == 40) btn_i = 4'b0000;
      step();
      chk($sformatf("rep_press_e%0d", e), press_o,
          (e == 5 || (e >= 15 && e < 45 && (e - 15) % 3 == 0)) ? 4'b0001 : 4'b0000);
      chk($sformatf("rep_release_e%0d", e), release_o, e == 45 ? 4'b0001 : 4'b0000);
    end

    btn_i = 4'b1010;
    for (int e = 0; e < 20; e++) begin
      if (e == 8) btn_i = 4'b0000;
      step();
      chk($sformatf("sim_press_e%0d", e), press_o, e == 5 ? 4'b1010 : 4'b0000);
      chk($sformatf("sim_any_e%0d", e), {3'b000, any_level_o}, (e >= 5 && e < 13) ? 4'b0001 : 4'b0000);
      chk($sformatf("sim_release_e%0d", e), release_o, e == 13 ? 4'b1010 : 4'b0000);
    end

    btn_i = 4'b0010;
    repeat (5) step();
    rst_i = 1'b1;
    #1;
    chk("midrst_level", level_o, 4'b0000);
    chk("midrst_press", press_o, 4'b0000);
    repeat (2) step();
    rst_i = 1'b0;
    for (int e = 0; e < 8; e++) begin
      step();
      chk($sformatf("midrst_press_e%0d", e), press_o, e == 5 ? 4'b0010 : 4'b0000);
      chk($sformatf("midrst_level_e%0d", e), level_o, e >= 5 ? 4'b0010 : 4'b0000);
    end
    btn_i = 4'b0000;
    repeat (12) step();
    chk("midrst_idle", level_o, 4'b0000);

    btn_i = 4'b0001;
    repeat (17) step();
    chk("held_level", level_o, 4'b0001);
    rst_i = 1'b1;
    #1;
    chk("held_rst_level", level_o, 4'b0000);
    chk("held_rst_release", release_o, 4'b0000);
    btn_i = 4'b0000;
    repeat (2) step();
    rst_i = 1'b0;
    seen = '0;
    repeat (12) begin
      step();
      seen |= level_o | press_o | release_o;
    end
    chk("held_after_events", seen, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
